// File: rtl/risc_v_mike_wb_queue_if.sv
// Writeback queue bus: two result sources in, register-file write port out,
// and the decode-side forwarding lookup.
//
// Handshake semantics (src0 and src1 alike): a transfer happens on any rising
// clk edge where valid and ready are both high. ready is a function of
// registered queue state only, never of valid. A producer may raise valid at
// any time and must hold addr/data stable while valid is high and ready low.
interface risc_v_mike_wb_queue_if #(
  parameter int WB_FIFO_DEPTH = 4,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5
);
  localparam int CNT_W = $clog2(WB_FIFO_DEPTH) + 1;

  logic              src0_valid;
  logic              src0_ready;
  logic [ADDR_W-1:0] src0_addr;
  logic [DATA_W-1:0] src0_data;
  logic              src1_valid;
  logic              src1_ready;
  logic [ADDR_W-1:0] src1_addr;
  logic [DATA_W-1:0] src1_data;
  logic              reg_file_write;
  logic [ADDR_W-1:0] reg_file_wr_addr;
  logic [DATA_W-1:0] reg_file_wr_data;
  logic [ADDR_W-1:0] fwd_addr_1;
  logic [ADDR_W-1:0] fwd_addr_2;
  logic              fwd_hit_1;
  logic [DATA_W-1:0] fwd_data_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_2;
  logic              wb_busy;
  // Occupancy of the pending-write FIFO, exported for observation.
  logic [CNT_W-1:0]  dbg_count;

  modport master (
    output src0_valid, src0_addr, src0_data,
    output src1_valid, src1_addr, src1_data,
    output fwd_addr_1, fwd_addr_2,
    input  src0_ready, src1_ready,
    input  reg_file_write, reg_file_wr_addr, reg_file_wr_data,
    input  fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2,
    input  wb_busy, dbg_count
  );

  modport slave (
    input  src0_valid, src0_addr, src0_data,
    input  src1_valid, src1_addr, src1_data,
    input  fwd_addr_1, fwd_addr_2,
    output src0_ready, src1_ready,
    output reg_file_write, reg_file_wr_addr, reg_file_wr_data,
    output fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2,
    output wb_busy, dbg_count
  );
endinterface

// File: rtl/risc_v_mike_wb_queue.sv
// Writeback queue: merges ALU (src0) and LSU (src1) results into one in-order
// register-file write stream through a small FIFO, and offers a combinational
// forwarding lookup over everything not yet written.
module risc_v_mike_wb_queue #(
  parameter int WB_FIFO_DEPTH = 4,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5
) (
  input logic                    clk,
  input logic                    rst,
  risc_v_mike_wb_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(WB_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEPTH_C    = cnt_t'(WB_FIFO_DEPTH);
  localparam cnt_t DEPTH_M1_C = cnt_t'(WB_FIFO_DEPTH - 1);

  logic [ADDR_W-1:0] mem_addr [WB_FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [WB_FIFO_DEPTH];

  ptr_t rd_ptr;
  ptr_t wr_ptr;
  cnt_t count;

  logic              out_write;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  logic src0_ready;
  logic src1_ready;
  logic push0;
  logic push1;
  logic pop;
  ptr_t slot1;

  // src1 needs one slot of headroom so it always fits behind a same-cycle src0.
  assign src0_ready = (count < DEPTH_C);
  assign src1_ready = (count < DEPTH_M1_C);

  // x0 writes complete the handshake but are never enqueued.
  assign push0 = bus.src0_valid & src0_ready & (bus.src0_addr != '0);
  assign push1 = bus.src1_valid & src1_ready & (bus.src1_addr != '0);
  assign pop   = (count != '0);
  assign slot1 = push0 ? ptr_t'(wr_ptr + ptr_t'(1)) : wr_ptr;

  // Entry storage; contents are meaningless outside the head..tail window.
  always_ff @(posedge clk) begin
    if (push0) begin
      mem_addr[wr_ptr] <= bus.src0_addr;
      mem_data[wr_ptr] <= bus.src0_data;
    end
    if (push1) begin
      mem_addr[slot1] <= bus.src1_addr;
      mem_data[slot1] <= bus.src1_data;
    end
  end

  // Pointers and occupancy; src0 lands before src1 when both push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + ptr_t'(pop);
      wr_ptr <= wr_ptr + ptr_t'(push0) + ptr_t'(push1);
      count  <= count + cnt_t'(push0) + cnt_t'(push1) - cnt_t'(pop);
    end
  end

  // Output stage: drain one entry per cycle; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_write <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      out_write <= pop;
      if (pop) begin
        out_addr <= mem_addr[rd_ptr];
        out_data <= mem_data[rd_ptr];
      end
    end
  end

  logic              hit_1;
  logic              hit_2;
  logic [DATA_W-1:0] data_1;
  logic [DATA_W-1:0] data_2;
  ptr_t              idx;

  // Forwarding: walk oldest (output stage) to youngest (tail-1) so the last match wins.
  always_comb begin
    hit_1  = 1'b0;
    hit_2  = 1'b0;
    data_1 = '0;
    data_2 = '0;
    idx    = rd_ptr;
    if (out_write && (out_addr == bus.fwd_addr_1)) begin
      hit_1  = 1'b1;
      data_1 = out_data;
    end
    if (out_write && (out_addr == bus.fwd_addr_2)) begin
      hit_2  = 1'b1;
      data_2 = out_data;
    end
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      idx = rd_ptr + ptr_t'(i);
      if (cnt_t'(i) < count) begin
        if (mem_addr[idx] == bus.fwd_addr_1) begin
          hit_1  = 1'b1;
          data_1 = mem_data[idx];
        end
        if (mem_addr[idx] == bus.fwd_addr_2) begin
          hit_2  = 1'b1;
          data_2 = mem_data[idx];
        end
      end
    end
    if (bus.fwd_addr_1 == '0) begin
      hit_1  = 1'b0;
      data_1 = '0;
    end
    if (bus.fwd_addr_2 == '0) begin
      hit_2  = 1'b0;
      data_2 = '0;
    end
  end

  assign bus.src0_ready       = src0_ready;
  assign bus.src1_ready       = src1_ready;
  assign bus.reg_file_write   = out_write;
  assign bus.reg_file_wr_addr = out_addr;
  assign bus.reg_file_wr_data = out_data;
  assign bus.fwd_hit_1        = hit_1;
  assign bus.fwd_data_1       = data_1;
  assign bus.fwd_hit_2        = hit_2;
  assign bus.fwd_data_2       = data_2;
  assign bus.wb_busy          = pop | out_write;
  assign bus.dbg_count        = count;
endmodule

// File: tb/tb_risc_v_mike_wb_queue.sv
// Bench for the writeback queue: a cycle table for latency, forwarding and
// x0 handling, then hand-written sequences for backpressure, async reset and
// streaming with pointer wrap.
module tb_risc_v_mike_wb_queue;
  logic clk;
  logic rst;

  risc_v_mike_wb_queue_if #(.WB_FIFO_DEPTH(4), .DATA_W(32), .ADDR_W(5)) bus ();

  risc_v_mike_wb_queue #(.WB_FIFO_DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  bit chk_en = 1'b0;
  logic [36:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every register-file write must match the head of exp_q.
  always @(negedge clk) begin
    if (chk_en && !rst && bus.reg_file_write === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_unexpected: got %0h/%0h expected none",
                 bus.reg_file_wr_addr, bus.reg_file_wr_data);
      end else begin
        check("wb_order", {27'd0, bus.reg_file_wr_addr, bus.reg_file_wr_data}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle_inputs();
    bus.src0_valid = 1'b0; bus.src0_addr = '0; bus.src0_data = '0;
    bus.src1_valid = 1'b0; bus.src1_addr = '0; bus.src1_data = '0;
    bus.fwd_addr_1 = '0;   bus.fwd_addr_2 = '0;
  endtask

  typedef struct {
    logic        s0v; logic [4:0] s0a; logic [31:0] s0d;
    logic        s1v; logic [4:0] s1a; logic [31:0] s1d;
    logic [4:0]  f1;  logic [4:0] f2;
    logic        we;  logic [4:0] wa;  logic [31:0] wd;
    logic        h1;  logic [31:0] d1; logic h2; logic [31:0] d2;
    logic        r0;  logic r1;  logic busy;
  } vec_t;

  vec_t tv[12];

  int r1_exp[7]  = '{1, 1, 0, 0, 0, 1, 1};
  int cnt_exp[7] = '{0, 2, 3, 3, 3, 2, 2};

  initial begin
    // Cycle table: inputs applied in a cycle, outputs expected in that same cycle.
    //          s0v  s0a   s0d       s1v  s1a   s1d     f1    f2    we   wa    wd        h1   d1        h2   d2        r0   r1   busy
    tv[0]  = '{1'b1, 5'd5, 32'h11,   1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 32'h11, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1};
    tv[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 5'd5, 32'h11, 1'b1, 32'h11, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1};
    tv[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd5, 32'h11, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 5'd3, 32'hA,    1'b1, 5'd3, 32'hB, 5'd3, 5'd5, 1'b0, 5'd5, 32'h11, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd5, 32'h11, 1'b1, 32'hB,  1'b1, 32'hB,  1'b1, 1'b1, 1'b1};
    tv[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 1'b1, 5'd3, 32'hA,  1'b1, 32'hB,  1'b0, 32'h0,  1'b1, 1'b1, 1'b1};
    tv[7]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3, 32'hB,  1'b1, 32'hB,  1'b1, 32'hB,  1'b1, 1'b1, 1'b1};
    tv[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd3, 32'hB,  1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd3, 32'hB,  1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    tv[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd3, 32'hB,  1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0};
    tv[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd3, 32'hB,  1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0};

    // Reset
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_we",    bus.reg_file_write,   0);
    check("rst_addr",  bus.reg_file_wr_addr, 0);
    check("rst_data",  bus.reg_file_wr_data, 0);
    check("rst_count", bus.dbg_count,        0);
    check("rst_busy",  bus.wb_busy,          0);
    rst = 1'b0;

    // Table: single write latency, same-cycle dual push, forwarding, x0 drop
    for (int v = 0; v < 12; v++) begin
      bus.src0_valid = tv[v].s0v; bus.src0_addr = tv[v].s0a; bus.src0_data = tv[v].s0d;
      bus.src1_valid = tv[v].s1v; bus.src1_addr = tv[v].s1a; bus.src1_data = tv[v].s1d;
      bus.fwd_addr_1 = tv[v].f1;  bus.fwd_addr_2 = tv[v].f2;
      #1;
      check($sformatf("v%0d_we", v),   bus.reg_file_write,   tv[v].we);
      check($sformatf("v%0d_wa", v),   bus.reg_file_wr_addr, tv[v].wa);
      check($sformatf("v%0d_wd", v),   bus.reg_file_wr_data, tv[v].wd);
      check($sformatf("v%0d_h1", v),   bus.fwd_hit_1,        tv[v].h1);
      check($sformatf("v%0d_d1", v),   bus.fwd_data_1,       tv[v].d1);
      check($sformatf("v%0d_h2", v),   bus.fwd_hit_2,        tv[v].h2);
      check($sformatf("v%0d_d2", v),   bus.fwd_data_2,       tv[v].d2);
      check($sformatf("v%0d_r0", v),   bus.src0_ready,       tv[v].r0);
      check($sformatf("v%0d_r1", v),   bus.src1_ready,       tv[v].r1);
      check($sformatf("v%0d_busy", v), bus.wb_busy,          tv[v].busy);
      @(negedge clk);
    end
    idle_inputs();

    // Backpressure: both sources push every cycle, src1 stalls at count 3
    begin
      int i0 = 0;
      int i1 = 0;
      int cyc = 0;
      int lim = 0;
      logic [4:0] acc_order[8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd6, 5'd8};
      for (int k = 0; k < 8; k++) exp_q.push_back({acc_order[k], 32'h100 + 32'(acc_order[k])});
      chk_en = 1'b1;
      while ((i0 < 4 || i1 < 4) && cyc < 40) begin
        bus.src0_valid = (i0 < 4); bus.src0_addr = 5'(2 * i0 + 1); bus.src0_data = 32'h100 + 32'(2 * i0 + 1);
        bus.src1_valid = (i1 < 4); bus.src1_addr = 5'(2 * i1 + 2); bus.src1_data = 32'h100 + 32'(2 * i1 + 2);
        #1;
        if (cyc < 7) begin
          check($sformatf("t3_r1_c%0d", cyc),  bus.src1_ready, r1_exp[cyc]);
          check($sformatf("t3_cnt_c%0d", cyc), bus.dbg_count,  cnt_exp[cyc]);
        end
        check($sformatf("t3_r0_c%0d", cyc), bus.src0_ready, 1);
        if (bus.src0_valid && bus.src0_ready) i0++;
        if (bus.src1_valid && bus.src1_ready) i1++;
        cyc++;
        @(negedge clk);
      end
      check("t3_cycles", cyc, 7);
      idle_inputs();
      while ((exp_q.size() != 0 || bus.wb_busy) && lim < 30) begin
        lim++;
        @(negedge clk);
      end
      check("t3_drain", exp_q.size(), 0);
      check("t3_idle",  bus.wb_busy,  0);
    end

    // Async reset with three entries pending and one in the output stage
    chk_en = 1'b0;
    exp_q.delete();
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd9;  bus.src0_data = 32'h9;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd10; bus.src1_data = 32'hA0;
    @(negedge clk);
    bus.src0_addr = 5'd11; bus.src0_data = 32'hB0;
    bus.src1_addr = 5'd12; bus.src1_data = 32'hC0;
    @(negedge clk);
    idle_inputs();
    bus.fwd_addr_1 = 5'd12;
    bus.fwd_addr_2 = 5'd11;
    #1;
    check("t5_cnt_pre", bus.dbg_count,      3);
    check("t5_we_pre",  bus.reg_file_write, 1);
    check("t5_hit_pre", bus.fwd_data_1,     32'hC0);
    #2 rst = 1'b1;
    #1;
    check("t5_we_rst",   bus.reg_file_write,   0);
    check("t5_addr_rst", bus.reg_file_wr_addr, 0);
    check("t5_data_rst", bus.reg_file_wr_data, 0);
    check("t5_cnt_rst",  bus.dbg_count,        0);
    check("t5_busy_rst", bus.wb_busy,          0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t5_we_after%0d", k), bus.reg_file_write, 0);
      check($sformatf("t5_h1_after%0d", k), bus.fwd_hit_1,      0);
      check($sformatf("t5_h2_after%0d", k), bus.fwd_hit_2,      0);
    end
    idle_inputs();

    // Stream 20 src0 writes back to back; forward lookups straddle pointer wrap
    begin
      int w0;
      int lim = 0;
      for (int k = 0; k < 20; k++) exp_q.push_back({5'(k + 1), 32'h2000 + 32'(k)});
      w0 = n_writes;
      chk_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
        bus.src0_valid = 1'b1; bus.src0_addr = 5'(k + 1); bus.src0_data = 32'h2000 + 32'(k);
        bus.fwd_addr_1 = (k > 0) ? 5'(k) : 5'd0;
        #1;
        check($sformatf("t6_r0_%0d", k),  bus.src0_ready, 1);
        check($sformatf("t6_cnt_%0d", k), bus.dbg_count,  (k == 0) ? 0 : 1);
        if (k >= 2) check($sformatf("t6_we_%0d", k), bus.reg_file_write, 1);
        if (k == 4 || k == 8 || k == 12 || k == 16)
          check($sformatf("t6_wrap_%0d", k), bus.fwd_data_1, 32'h2000 + 32'(k - 1));
        @(negedge clk);
      end
      idle_inputs();
      while ((exp_q.size() != 0 || bus.wb_busy) && lim < 20) begin
        lim++;
        @(negedge clk);
      end
      check("t6_drain",  exp_q.size(),      0);
      check("t6_writes", n_writes - w0,     20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
